// File: rtl/map_pkg.sv
// Shared types and constants for the map pixel fetch path.
// The coordinate helper turns a screen position plus camera offset into a wrapped map coordinate.
package map_pkg;

   localparam int MAP_DIM = 256;
   localparam int MAP_AW  = 16;
   localparam int RGB_W   = 24;

   typedef logic [RGB_W-1:0] rgb_t;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      WAIT_VB = 2'd1,
      SWAP    = 2'd2,
      FLUSH   = 2'd3
   } map_fsm_t;

   // Downscale the screen coordinate, then add the camera offset modulo the map dimension.
   function automatic logic [7:0] map_coord(input logic [9:0] i_screen,
                                            input logic [7:0] i_cam,
                                            input int         i_shift);
      logic [9:0] w_scaled;
      w_scaled = i_screen >> i_shift;
      return w_scaled[7:0] + i_cam;
   endfunction

endpackage

// File: rtl/map_tag_pipe.sv
// Fixed-depth shift register that carries per-pixel tags alongside the ROM read latency.
// Cleared asynchronously so no stale tag can surface after a reset.
module map_tag_pipe #(
   parameter int DEPTH = 2,
   parameter int W     = 2
) (
   input  logic         i_clock,
   input  logic         i_reset_n,
   input  logic [W-1:0] i_tag,
   output logic [W-1:0] o_tag
);

   logic [W-1:0] r_stage [DEPTH];

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= i_tag;
         for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/map_pixel_fetcher.sv
// Turns VGA draw coordinates plus camera offset into map ROM reads and realigns the returned
// pixels into a valid-tagged RGB stream; map switches are applied only during vertical blank.
module map_pixel_fetcher
   import map_pkg::*;
#(
   parameter int   H_ACTIVE    = 640,
   parameter int   V_ACTIVE    = 480,
   parameter int   SCALE_SHIFT = 1,
   parameter int   ROM_LAT     = 1,
   parameter rgb_t BORDER_RGB  = 24'h000000
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [9:0]        draw_x,
   input  logic [9:0]        draw_y,
   input  logic              pix_en,
   input  logic [7:0]        cam_x,
   input  logic [7:0]        cam_y,
   input  logic              map_req,
   input  rgb_t              rom_q,
   output logic [MAP_AW-1:0] rom_address,
   output logic              rom_selector,
   output rgb_t              rgb,
   output logic              rgb_valid,
   output logic              map_ack,
   output logic              switching,
   output map_fsm_t          o_dbg_state
);

   localparam int         TAG_DEPTH   = ROM_LAT + 1;
   localparam int         FCW         = $clog2(TAG_DEPTH + 1);
   localparam logic [9:0] LP_H_ACTIVE = 10'(H_ACTIVE);
   localparam logic [9:0] LP_V_ACTIVE = 10'(V_ACTIVE);
   localparam logic [FCW-1:0] FLUSH_INIT = FCW'(TAG_DEPTH);

   logic [7:0]        w_map_x;
   logic [7:0]        w_map_y;
   logic              w_active;
   logic [1:0]        w_tag_in;
   logic [1:0]        w_tag_out;

   logic [MAP_AW-1:0] r_addr;
   logic              r_sel;
   rgb_t              r_rgb;
   logic              r_valid;
   logic              r_ack;
   logic              r_switching;
   map_fsm_t          r_state;
   logic [FCW-1:0]    r_flush_cnt;

   assign w_map_x  = map_coord(draw_x, cam_x, SCALE_SHIFT);
   assign w_map_y  = map_coord(draw_y, cam_y, SCALE_SHIFT);
   assign w_active = (draw_x < LP_H_ACTIVE) && (draw_y < LP_V_ACTIVE);
   assign w_tag_in = {pix_en, w_active};

   map_tag_pipe #(
      .DEPTH (TAG_DEPTH),
      .W     (2)
   ) u_tag_pipe (
      .i_clock   (clock),
      .i_reset_n (reset_n),
      .i_tag     (w_tag_in),
      .o_tag     (w_tag_out)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_addr <= '0;
      end else if (pix_en) begin
         r_addr <= {w_map_y, w_map_x};
      end
   end

   // Map switch control: the selector only ever moves in SWAP, and FLUSH covers every read
   // that was issued against the old map before the selector changed.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= RUN;
         r_sel       <= 1'b0;
         r_ack       <= 1'b0;
         r_switching <= 1'b0;
         r_flush_cnt <= '0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            RUN: begin
               if (map_req != r_sel) begin
                  r_state     <= WAIT_VB;
                  r_switching <= 1'b1;
               end
            end
            WAIT_VB: begin
               if (map_req == r_sel) begin
                  r_state     <= RUN;
                  r_switching <= 1'b0;
               end else if (pix_en && (draw_y >= LP_V_ACTIVE)) begin
                  r_state <= SWAP;
               end
            end
            SWAP: begin
               r_sel       <= map_req;
               r_flush_cnt <= FLUSH_INIT;
               r_state     <= FLUSH;
            end
            FLUSH: begin
               if (r_flush_cnt <= FCW'(1)) begin
                  r_flush_cnt <= '0;
                  r_state     <= RUN;
                  r_ack       <= 1'b1;
                  r_switching <= 1'b0;
               end else begin
                  r_flush_cnt <= r_flush_cnt - FCW'(1);
               end
            end
            default: begin
               r_state     <= RUN;
               r_switching <= 1'b0;
            end
         endcase
      end
   end

   // Pixels are only trusted while running normally; anything mid-switch shows the border colour.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rgb   <= BORDER_RGB;
         r_valid <= 1'b0;
      end else if (w_tag_out[1]) begin
         r_valid <= 1'b1;
         r_rgb   <= (w_tag_out[0] && (r_state == RUN)) ? rom_q : BORDER_RGB;
      end else begin
         r_valid <= 1'b0;
      end
   end

   assign rom_address  = r_addr;
   assign rom_selector = r_sel;
   assign rgb          = r_rgb;
   assign rgb_valid    = r_valid;
   assign map_ack      = r_ack;
   assign switching    = r_switching;
   assign o_dbg_state  = r_state;

endmodule
